edge_event_arbiter: RTL

//  - Detects configurable edges on N single-bit, clk-synchronous event lines and latches each detected edge as a pending request.
//  - Shares one downstream event port among the N channels using round-robin arbitration with a valid/ready handshake.
//  - Sits between raw status/strobe lines and a single event consumer, such as an IRQ or log unit.

---
 rtl/edge_event_pkg.sv | 30 +++
 rtl/edge_event_cell.sv | 44 ++++
 rtl/edge_event_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/edge_event_pkg.sv
// Shared types for the edge event arbiter: edge-select encoding, FSM states
// and the per-channel edge qualifier.
package edge_event_pkg;

  typedef enum logic [1:0] {
    EM_RISE = 2'b00,
    EM_FALL = 2'b01,
    EM_BOTH = 2'b10,
    EM_OFF  = 2'b11
  } edge_mode_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  // A both-edge channel reports any change; the direction is not kept.
  function automatic logic edge_hit(edge_mode_t mode, logic cur, logic prev);
    logic hit;
    hit = 1'b0;
    case (mode)
      EM_RISE: hit = cur & ~prev;
      EM_FALL: hit = ~cur & prev;
      EM_BOTH: hit = cur ^ prev;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_event_cell.sv
// One event channel: edge detection, pending request latch and sticky
// overflow flag.
module edge_event_cell
  import edge_event_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  input  logic [1:0] edge_mode,
  input  logic       ack,
  input  logic       ovf_clr,
  output logic       pending,
  output logic       overflow
);

  logic prev;
  logic hit;
  logic ovf_set;

  assign hit     = edge_hit(edge_mode_t'(edge_mode), data_in, prev);
  // A hit on the channel being acked replaces the delivered request, so it is not lost.
  assign ovf_set = hit & pending & ~ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prev <= data_in;

      if (hit)
        pending <= 1'b1;
      else if (ack)
        pending <= 1'b0;

      if (ovf_set)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Latches configurable edges on N event lines and offers them one at a time
// on a valid/ready port using round-robin arbitration.
module edge_event_arbiter
  import edge_event_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     data_in,
  input  logic [2*N-1:0]   edge_mode,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [IDW-1:0]   evt_id,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     overflow
);

  // state   | meaning
  // S_IDLE  | nothing offered; picks a winner when any request is pending
  // S_OFFER | evt_id offered with evt_valid=1 until the consumer takes it

  state_t         state, state_nxt;
  logic [IDW-1:0] evt_id_nxt;
  logic [IDW-1:0] last_grant, last_grant_nxt;
  logic [IDW-1:0] winner;
  logic           handshake;
  logic [N-1:0]   ack;

  assign evt_valid = (state == S_OFFER);
  assign handshake = evt_valid & evt_ready;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign ack[i] = handshake & (evt_id == IDW'(i));

    edge_event_cell u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in[i]),
      .edge_mode (edge_mode[2*i +: 2]),
      .ack       (ack[i]),
      .ovf_clr   (ovf_clr),
      .pending   (pending[i]),
      .overflow  (overflow[i])
    );
  end

  // Search starts one past the last grant and wraps, so every channel is reached within N grants.
  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(last_grant) + k) % N);
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    evt_id_nxt     = evt_id;
    last_grant_nxt = last_grant;
    case (state)
      S_IDLE: begin
        if (|pending) begin
          state_nxt  = S_OFFER;
          evt_id_nxt = winner;
        end
      end
      S_OFFER: begin
        if (evt_ready) begin
          state_nxt      = S_IDLE;
          last_grant_nxt = evt_id;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      evt_id     <= '0;
      last_grant <= IDW'(N - 1);
    end else begin
      state      <= state_nxt;
      evt_id     <= evt_id_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule
